// File: rtl/dac_serial_tx.sv
// Requantizes 32-bit filter samples to 16-bit codes and shifts them out MSB-first to a serial DAC.
// Capture-to-cs_n-low is 2 cycles; one-deep holding register, samples arriving while full are dropped (ovf).
module dac_serial_tx #(
    parameter int SHIFT   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] yn,
    input  logic               yn_valid,
    output logic               ready,
    output logic               dac_cs_n,
    output logic               dac_sclk,
    output logic               dac_sdo,
    output logic               ovf,
    output logic               sat
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MID = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(2 * CLK_DIV - 1);
    // Half-LSB rounding constant; evaluates to zero when SHIFT is zero.
    localparam logic signed [32:0] ROUND = (33'sd1 <<< SHIFT) >>> 1;

    state_t           state_q, state_d;
    logic             full_q, full_d;
    logic [15:0]      hold_q, hold_d;
    logic [15:0]      shreg_q, shreg_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             ovf_q, ovf_d;
    logic             sat_q, sat_d;
    logic             ready_q, ready_d;

    logic signed [32:0] yn_ext;
    logic signed [32:0] sum;
    logic signed [32:0] q;
    logic [15:0]        code;
    logic               clip;
    logic               load;

    assign yn_ext = {yn[31], yn};
    assign sum    = yn_ext + ROUND;
    assign q      = sum >>> SHIFT;

    always_comb begin
        code = q[15:0];
        clip = 1'b0;
        if (q > 33'sd32767) begin
            code = 16'h7FFF;
            clip = 1'b1;
        end else if (q < -33'sd32768) begin
            code = 16'h8000;
            clip = 1'b1;
        end
    end

    assign load = (state_q == ST_IDLE) && full_q;

    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        hold_d    = hold_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        ovf_d     = 1'b0;
        sat_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (full_q) begin
                    state_d   = ST_SETUP;
                    shreg_d   = hold_q;
                    cs_n_d    = 1'b0;
                    sdo_d     = hold_q[15];
                    sclk_d    = 1'b0;
                    bit_cnt_d = 4'd0;
                    div_d     = '0;
                end
            end
            ST_SETUP: begin
                state_d = ST_SHIFT;
                div_d   = '0;
            end
            ST_SHIFT: begin
                if (div_q == DIV_END) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_cnt_q == 4'd15) begin
                        state_d = ST_HOLD;
                        cs_n_d  = 1'b1;
                        sdo_d   = 1'b0;
                    end else begin
                        shreg_d   = {shreg_q[14:0], 1'b0};
                        sdo_d     = shreg_q[14];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    if (div_q == DIV_MID) begin
                        sclk_d = 1'b1;
                    end
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A sample landing on the same edge the holder empties into the shifter is accepted.
        if (load) begin
            full_d = 1'b0;
        end
        if (yn_valid) begin
            if (!full_q || load) begin
                hold_d = code;
                full_d = 1'b1;
                sat_d  = clip;
            end else begin
                ovf_d = 1'b1;
            end
        end

        ready_d = !full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            full_q    <= 1'b0;
            hold_q    <= 16'h0000;
            shreg_q   <= 16'h0000;
            bit_cnt_q <= 4'd0;
            div_q     <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            hold_q    <= hold_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
            ready_q   <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_sdo  = sdo_q;
    assign ovf      = ovf_q;
    assign sat      = sat_q;

endmodule

// File: doc/dac_serial_tx.md
DAC_SERIAL_TX -- requirements
Module: dac_serial_tx

Interface
REQ-001 Parameter: SHIFT, default 8, right-shift applied to the 32-bit filter output before requantization (0 to 16).
REQ-002 Parameter: CLK_DIV, default 2, dac_sclk half-period in clk cycles (≥1).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 yn  input  32 signed  filter output sample.
REQ-006 yn_valid  input  1  one-cycle qualifier; yn is captured when yn_valid=1.
REQ-007 ready  output  1  high when the holding register is empty.
REQ-008 dac_cs_n  output  1  active-low frame select.
REQ-009 dac_sclk  output  1  serial clock; idles low.
REQ-010 dac_sdo  output  1  serial data, MSB first.
REQ-011 ovf  output  1  one-cycle pulse when a sample is dropped.
REQ-012 sat  output  1  one-cycle pulse when a captured sample saturates.

Function
REQ-013 Requantize: if SHIFT>0, the block SHALL compute q = (yn + 2^(SHIFT-1)) >>> SHIFT in 33-bit arithmetic; if SHIFT=0, q = yn.
REQ-014 The block SHALL saturate q to [-32768, 32767], producing a 16-bit two's-complement code, and SHALL pulse sat in the cycle after capture if clipping occurred.
REQ-015 Buffering SHALL be one holding register (code plus full flag) feeding one shift register; ready = !full.
REQ-016 When yn_valid=1 and the holding register is empty, the block SHALL capture the requantized code into the holding register.
REQ-017 When yn_valid=1 and the holding register is full, the block SHALL drop the new sample, keep the held code, and pulse ovf for one cycle.
REQ-018 When yn_valid=1 coincides with the holding register emptying into the shifter, the block SHALL capture the new sample and SHALL NOT flag ovf.
REQ-019 FSM states: IDLE, SETUP, SHIFT, HOLD.
REQ-020 IDLE → SETUP when the holding register is full: load the shifter, clear full, dac_cs_n←0, dac_sdo←bit15.
REQ-021 SETUP lasts 1 cycle, then → SHIFT.
REQ-022 In SHIFT, each of 16 bits SHALL last 2*CLK_DIV cycles: dac_sclk low for the first CLK_DIV cycles, high for the last CLK_DIV; dac_sdo SHALL change only on the cycle dac_sclk falls (the end of a bit), presenting the next bit.
REQ-023 After bit 0's high phase the block SHALL go → HOLD with dac_sclk←0 and dac_cs_n←1.
REQ-024 HOLD lasts 1 cycle, then → IDLE; frames are therefore separated by ≥2 cycles with dac_cs_n high (HOLD + IDLE).
REQ-025 Frame length with dac_cs_n low SHALL be exactly 1 + 32*CLK_DIV cycles.
REQ-026 Latency: with the block idle and the holding register empty, yn_valid at edge n SHALL give full=1 at n+1 and dac_cs_n=0 at n+2.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While reset=1 at a clk edge, the block SHALL set state=IDLE, full=0, shifter=0, bit counter=0, and divider=0.
REQ-029 Reset SHALL drive ready=1, dac_cs_n=1, dac_sclk=0, dac_sdo=0, ovf=0, sat=0.
REQ-030 Reset mid-frame SHALL abort the frame immediately (dac_cs_n=1 at the next edge) and discard the held sample.
REQ-031 yn_valid asserted while reset=1 SHALL be ignored.

Verification (SHIFT=8, CLK_DIV=2)
REQ-032 Capture yn=25600 → frame on dac_sdo of 0x0064, dac_cs_n low for 65 cycles, 16 sclk rising edges, sat=0.
REQ-033 Capture yn=0x7FFFFFFF → frame 0x7FFF and sat pulse; capture yn=0x80000000 → frame 0x8000 and sat pulse.
REQ-034 Capture yn=-200 → frame 0xFFFF; capture yn=384 → frame 0x0002; capture yn=-32768·256 → frame 0x8000, no sat.
REQ-035 Apply yn_valid for samples A, B, C on three consecutive cycles → A sent, B held then sent, C dropped with one ovf pulse, ready=0 while B is held.
REQ-036 Assert reset during bit 7 of a frame while a second sample is held → dac_cs_n=1 on the next edge, no further frame, ready=1.
REQ-037 A reference model of REQ-013/014 SHALL be checked over 10k random yn values, with every frame's decoded bits matching the model.
